// File: rtl/result_checker.sv
// Snoops the data-memory write bus, arms on a begin symbol written to the test port and
// scores each following result write against an external expected-value ROM.
module result_checker #(
   parameter int unsigned           ADDR_W     = 30,
   parameter int unsigned           DATA_W     = 32,
   parameter logic [ADDR_W-1:0]     TEST_PORT  = 30'h10,
   parameter logic [DATA_W-1:0]     BEGIN_SYM  = 32'h00000168,
   parameter int unsigned           CHECK_NUM  = 19,
   parameter int unsigned           IDX_W      = 5,
   parameter logic [15:0]           TIMEOUT    = 16'hFFFF,
   parameter bit                    SWAP_BYTES = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   input  logic              hit_count,
   output logic [IDX_W-1:0]  exp_idx,
   input  logic [DATA_W-1:0] exp_data,
   output logic [7:0]        error_num,
   output logic [15:0]       duration,
   output logic [31:0]       cycle_count,
   output logic [31:0]       hit_cycles,
   output logic              finish,
   output logic              timeout,
   output logic              first_err_valid,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_got
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM);
   localparam logic [15:0]      TOUT_AT  = TIMEOUT - 16'd1;

   typedef enum logic [1:0] {StIdle, StCheck, StReport, StTout} state_e;

   state_e            state_q, state_d;
   logic              armed_q;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        error_num_q, error_num_d;
   logic [15:0]       duration_q, duration_d;
   logic [31:0]       cycle_count_q, hit_cycles_q;
   logic              first_err_valid_q, first_err_valid_d;
   logic [IDX_W-1:0]  first_err_idx_q, first_err_idx_d;
   logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
   logic [DATA_W-1:0] first_err_got_q, first_err_got_d;
   logic [DATA_W-1:0] cdata;
   logic              accept;

   always_comb begin
      cdata = data;
      if (SWAP_BYTES) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            cdata[8*b +: 8] = data[DATA_W-8-8*b +: 8];
         end
      end
   end

   // armed drops for the cycle after any write, so a stalled write counts once
   assign accept = wen && armed_q && (addr == TEST_PORT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && (cdata == BEGIN_SYM)) state_d = StCheck;
         end
         StCheck: begin
            if (idx_q == LAST_IDX) begin
               state_d = StReport;
            end else if ((TIMEOUT != 16'd0) && (duration_q == TOUT_AT)) begin
               state_d = StTout;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      finish  = (state_q == StReport) || (state_q == StTout);
      timeout = (state_q == StTout);
   end

   always_comb begin
      idx_d             = idx_q;
      error_num_d       = error_num_q;
      duration_d        = duration_q;
      first_err_valid_d = first_err_valid_q;
      first_err_idx_d   = first_err_idx_q;
      first_err_exp_d   = first_err_exp_q;
      first_err_got_d   = first_err_got_q;
      if (state_q == StIdle && state_d == StCheck) begin
         error_num_d = 8'd0;
      end
      if (state_q == StCheck) begin
         // the leaving edge does not count, so a watchdog exit reports TIMEOUT-1
         if (state_d == StCheck && duration_q != 16'hFFFF) duration_d = duration_q + 16'd1;
         if (accept && idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
            if (cdata != exp_data) begin
               if (error_num_q != 8'hFF) error_num_d = error_num_q + 8'd1;
               if (!first_err_valid_q) begin
                  first_err_valid_d = 1'b1;
                  first_err_idx_d   = idx_q;
                  first_err_exp_d   = exp_data;
                  first_err_got_d   = cdata;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed_q           <= 1'b1;
         idx_q             <= '0;
         error_num_q       <= 8'hFF;
         duration_q        <= 16'd0;
         cycle_count_q     <= 32'd0;
         hit_cycles_q      <= 32'd0;
         first_err_valid_q <= 1'b0;
         first_err_idx_q   <= '0;
         first_err_exp_q   <= '0;
         first_err_got_q   <= '0;
      end else begin
         armed_q           <= !wen;
         idx_q             <= idx_d;
         error_num_q       <= error_num_d;
         duration_q        <= duration_d;
         cycle_count_q     <= cycle_count_q + 32'd1;
         hit_cycles_q      <= hit_cycles_q + {31'd0, hit_count};
         first_err_valid_q <= first_err_valid_d;
         first_err_idx_q   <= first_err_idx_d;
         first_err_exp_q   <= first_err_exp_d;
         first_err_got_q   <= first_err_got_d;
      end
   end

   assign exp_idx         = idx_q;
   assign error_num       = error_num_q;
   assign duration        = duration_q;
   assign cycle_count     = cycle_count_q;
   assign hit_cycles      = hit_cycles_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_idx   = first_err_idx_q;
   assign first_err_exp   = first_err_exp_q;
   assign first_err_got   = first_err_got_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: per-cycle vector tables for full runs, hand sequences for
// ignored writes, watchdog and mid-test reset.
module tb_result_checker;

   localparam logic [29:0] TP    = 30'h10;
   localparam logic [31:0] BSYM  = 32'h00000168;
   localparam int          NCHK  = 19;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] addr = '0;
   logic [31:0] data = '0;
   logic        wen = 1'b0;
   logic        hit_count = 1'b0;

   logic [4:0]  exp_idx, first_err_idx;
   logic [31:0] exp_data, first_err_exp, first_err_got, cycle_count, hit_cycles;
   logic [7:0]  error_num;
   logic [15:0] duration;
   logic        finish, timeout, first_err_valid;

   logic [4:0]  exp_idx_t, first_err_idx_t;
   logic [31:0] exp_data_t, first_err_exp_t, first_err_got_t, cycle_count_t, hit_cycles_t;
   logic [7:0]  error_num_t;
   logic [15:0] duration_t;
   logic        finish_t, timeout_t, first_err_valid_t;

   function automatic logic [31:0] rom(input logic [4:0] i);
      if (i == 5'd3 || i == 5'd10) return 32'h0;
      return 32'hC0DE0000 + 32'(i) * 32'h0101;
   endfunction

   function automatic logic [31:0] swap(input logic [31:0] v);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = v[24-8*b +: 8];
      return r;
   endfunction

   assign exp_data   = rom(exp_idx);
   assign exp_data_t = rom(exp_idx_t);

   result_checker dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen), .hit_count(hit_count),
      .exp_idx(exp_idx), .exp_data(exp_data), .error_num(error_num), .duration(duration),
      .cycle_count(cycle_count), .hit_cycles(hit_cycles), .finish(finish), .timeout(timeout),
      .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
      .first_err_exp(first_err_exp), .first_err_got(first_err_got)
   );

   result_checker #(.TIMEOUT(16'd100)) dut_to (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen), .hit_count(hit_count),
      .exp_idx(exp_idx_t), .exp_data(exp_data_t), .error_num(error_num_t),
      .duration(duration_t), .cycle_count(cycle_count_t), .hit_cycles(hit_cycles_t),
      .finish(finish_t), .timeout(timeout_t), .first_err_valid(first_err_valid_t),
      .first_err_idx(first_err_idx_t), .first_err_exp(first_err_exp_t),
      .first_err_got(first_err_got_t)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_cyc, m_hit;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cyc <= 32'd0;
         m_hit <= 32'd0;
      end else begin
         m_cyc <= m_cyc + 32'd1;
         m_hit <= m_hit + {31'd0, hit_count};
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // one clock: drive at negedge, sample 1 time unit after the posedge
   task automatic step(input logic [29:0] a, input logic [31:0] v, input logic w);
      @(negedge clk);
      addr      = a;
      data      = swap(v);
      wen       = w;
      hit_count = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      repeat (2) step(30'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [29:0] addr;
      logic [31:0] val;
      logic        wen;
      logic [7:0]  exp_err;
      logic [4:0]  exp_idx;
      logic        exp_fin;
   } vec_t;

   vec_t vecs[$];
   int   p_begin, p_last;
   logic [7:0] run_err;

   task automatic push(input logic [29:0] a, input logic [31:0] v, input logic w,
                       input logic [7:0] e, input logic [4:0] ix, input logic f);
      vec_t t;
      t.addr = a; t.val = v; t.wen = w; t.exp_err = e; t.exp_idx = ix; t.exp_fin = f;
      vecs.push_back(t);
   endtask

   // begin symbol, then n result writes each held for 'hold' cycles, wen low in between
   task automatic build_run(input int n, input bit corrupt, input int hold);
      logic [31:0] val;
      logic [7:0]  e;
      vecs.delete();
      e = 8'd0;
      push(30'h0, 32'h0, 1'b0, 8'hFF, 5'd0, 1'b0);
      p_begin = vecs.size();
      push(TP, BSYM, 1'b1, 8'd0, 5'd0, 1'b0);
      push(30'h0, 32'h0, 1'b0, 8'd0, 5'd0, 1'b0);
      for (int i = 0; i < n; i++) begin
         val = (corrupt && (i == 3 || i == 10)) ? 32'h1 : rom(5'(i));
         if (val != rom(5'(i))) e++;
         for (int h = 0; h < hold; h++) begin
            if (h == 0) p_last = vecs.size();
            push(TP, val, 1'b1, e, 5'(i + 1), (i == NCHK - 1) && (h > 0));
         end
         push(30'h0, 32'h0, 1'b0, e, 5'(i + 1), i == NCHK - 1);
      end
      if (n == NCHK) begin
         push(TP, 32'hDEAD0000, 1'b1, e, 5'(NCHK), 1'b1);
         push(30'h0, 32'h0, 1'b0, e, 5'(NCHK), 1'b1);
         push(TP, BSYM, 1'b1, e, 5'(NCHK), 1'b1);
      end
      run_err = e;
   endtask

   task automatic apply(input string tag);
      foreach (vecs[i]) begin
         step(vecs[i].addr, vecs[i].val, vecs[i].wen);
         check($sformatf("%s v%0d error_num", tag, i), 32'(error_num), 32'(vecs[i].exp_err));
         check($sformatf("%s v%0d exp_idx", tag, i), 32'(exp_idx), 32'(vecs[i].exp_idx));
         check($sformatf("%s v%0d finish", tag, i), 32'(finish), 32'(vecs[i].exp_fin));
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, " cycle_count"}, cycle_count, m_cyc);
      check({tag, " hit_cycles"}, hit_cycles, m_hit);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " rst error_num"}, 32'(error_num), 32'hFF);
      check({tag, " rst duration"}, 32'(duration), 32'h0);
      check({tag, " rst exp_idx"}, 32'(exp_idx), 32'h0);
      check({tag, " rst cycle_count"}, cycle_count, 32'h0);
      check({tag, " rst hit_cycles"}, hit_cycles, 32'h0);
      check({tag, " rst finish"}, 32'(finish), 32'h0);
      check({tag, " rst timeout"}, 32'(timeout), 32'h0);
      check({tag, " rst first_err_valid"}, 32'(first_err_valid), 32'h0);
      check({tag, " rst first_err_idx"}, 32'(first_err_idx), 32'h0);
      check({tag, " rst first_err_exp"}, first_err_exp, 32'h0);
      check({tag, " rst first_err_got"}, first_err_got, 32'h0);
   endtask

   initial begin
      int steps;
      #12;
      check_reset_vals("init");
      @(negedge clk);
      rst = 1'b1;

      // clean run, one-cycle writes
      build_run(NCHK, 1'b0, 1);
      apply("clean");
      check("clean duration", 32'(duration), 32'(p_last - p_begin));
      check("clean timeout", 32'(timeout), 32'h0);
      check("clean first_err_valid", 32'(first_err_valid), 32'h0);
      check_counters("clean");

      // writes 3 and 10 corrupted
      do_reset();
      build_run(NCHK, 1'b1, 1);
      apply("corrupt");
      check("corrupt error_num", 32'(error_num), 32'd2);
      check("corrupt first_err_valid", 32'(first_err_valid), 32'h1);
      check("corrupt first_err_idx", 32'(first_err_idx), 32'd3);
      check("corrupt first_err_exp", first_err_exp, 32'h0);
      check("corrupt first_err_got", first_err_got, 32'h1);

      // each write stalled for four cycles
      do_reset();
      build_run(NCHK, 1'b0, 4);
      apply("stall");
      check("stall duration", 32'(duration), 32'(p_last - p_begin));
      check_counters("stall");

      // wrong address and non-begin value in IDLE are ignored
      do_reset();
      step(30'h0, 32'h0, 1'b0);
      step(30'h14, BSYM, 1'b1);
      step(30'h0, 32'h0, 1'b0);
      step(TP, 32'h00000167, 1'b1);
      step(30'h0, 32'h0, 1'b0);
      step(TP, rom(5'd0), 1'b1);
      step(30'h0, 32'h0, 1'b0);
      check("idle error_num", 32'(error_num), 32'hFF);
      check("idle duration", 32'(duration), 32'h0);
      check("idle exp_idx", 32'(exp_idx), 32'h0);
      check("idle finish", 32'(finish), 32'h0);

      // watchdog on the TIMEOUT=100 instance
      do_reset();
      step(30'h0, 32'h0, 1'b0);
      step(TP, BSYM, 1'b1);
      steps = 0;
      for (int i = 0; i < 5; i++) begin
         step(30'h0, 32'h0, 1'b0);
         step(TP, rom(5'(i)), 1'b1);
         steps += 2;
      end
      while (!finish_t && steps < 200) begin
         step(30'h0, 32'h0, 1'b0);
         steps++;
      end
      check("tout edges to finish", 32'(steps), 32'd100);
      check("tout timeout", 32'(timeout_t), 32'h1);
      check("tout finish", 32'(finish_t), 32'h1);
      check("tout duration", 32'(duration_t), 32'd99);
      check("tout error_num", 32'(error_num_t), 32'd0);
      check("tout big-limit finish", 32'(finish), 32'h0);
      for (int i = 0; i < 2; i++) begin
         step(TP, 32'hBAD00000, 1'b1);
         step(30'h0, 32'h0, 1'b0);
      end
      check("tout after error_num", 32'(error_num_t), 32'd0);
      check("tout after exp_idx", 32'(exp_idx_t), 32'd5);
      check("tout after duration", 32'(duration_t), 32'd99);

      // reset asserted mid-test, then a full clean run
      do_reset();
      build_run(10, 1'b0, 1);
      apply("partial");
      rst = 1'b0;
      #1;
      check_reset_vals("mid");
      repeat (2) step(30'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      build_run(NCHK, 1'b0, 1);
      apply("rerun");
      check("rerun error_num", 32'(error_num), 32'(run_err));
      check("rerun finish", 32'(finish), 32'h1);
      check_counters("rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
